qsram_access_sequencer: RTL and testbench
=========================================

QSRAM_ACCESS_SEQUENCER -- requirements
Module: qsram_access_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per row word.
REQ-002 SHALL have parameter ROWS, default 8: number of cell rows; valid range is 2 or more.
REQ-003 SHALL have parameter REFRESH_INTERVAL, default 64: cycles between refresh requests; valid range is 4 or more.
REQ-004 SHALL have port Clock, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL have port ReqValid, input, 1 bit: access request present.
REQ-007 SHALL have port ReqReady, output, 1 bit: sequencer accepts a request this cycle.
REQ-008 SHALL have port ReqWrite, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port ReqAddr, input, clog2(ROWS) bits: row address.
REQ-010 SHALL have port ReqData, input, WIDTH bits: write data.
REQ-011 SHALL have port RspValid, output, 1 bit: one-cycle pulse carrying read data.
REQ-012 SHALL have port RspData, output, WIDTH bits: read data.
REQ-013 SHALL have port AddrError, output, 1 bit: one-cycle pulse for an out-of-range address.
REQ-014 SHALL have port RefreshOverrun, output, 1 bit: sticky flag for a missed refresh slot.
REQ-015 SHALL have port RowSelect, output, ROWS bits: one-hot row enable to the cell array.
REQ-016 SHALL have port inputData, output, WIDTH bits: write data to the cells.
REQ-017 SHALL have port outputData, input, WIDTH bits: read data from the cells.
REQ-018 SHALL have ports WriteEdge, ReadEdge and RefreshEdge, each an output of 1 bit: cell strobes.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, STROBE, HOLD, REF_SETUP and REF_STROBE.
REQ-020 ReqReady SHALL be 1 only when the state is IDLE and no refresh is pending.
REQ-021 A request accepted in cycle T SHALL drive RowSelect and inputData, registered, from T+1 (SETUP) through T+3 (HOLD).
REQ-022 At T+2 (STROBE), WriteEdge or ReadEdge SHALL be 1 for exactly one cycle, according to ReqWrite.
REQ-023 For a read, outputData SHALL be captured at the end of HOLD; RspValid SHALL be 1 and RspData valid at T+4; RspValid has no backpressure.
REQ-024 After HOLD the state SHALL be IDLE, so the next accept is possible at T+4 (4-cycle throughput).
REQ-025 A write SHALL produce no RspValid.
REQ-026 A request with ReqAddr >= ROWS SHALL still be accepted, with:
- no strobe and RowSelect all zero;
- AddrError pulsed at T+1;
- for a read, RspValid at T+4 with RspData = 0.
REQ-027 The refresh timer SHALL count 0 to REFRESH_INTERVAL-1, wrap, and run continuously.
REQ-028 At the terminal count the timer SHALL set RefreshPending.
REQ-029 If RefreshPending is already set at the terminal count, RefreshOverrun SHALL be set; it is cleared only by Reset.
REQ-030 In IDLE with RefreshPending set, refresh SHALL take priority over ReqValid:
- REF_SETUP: RowSelect = one-hot(RefreshRow);
- REF_STROBE: RefreshEdge = 1 for one cycle;
- then IDLE, with RefreshPending cleared and RefreshRow incremented, wrapping ROWS-1 to 0.
REQ-031 An access in progress SHALL never be aborted by a refresh event.
REQ-032 At most one of WriteEdge, ReadEdge and RefreshEdge SHALL be 1 in any cycle.
REQ-033 RowSelect SHALL be all zero in IDLE.

Reset
REQ-034 Reset SHALL, on the next edge and even mid-operation, force:
- state IDLE;
- every strobe, RspValid and AddrError to 0;
- RowSelect, inputData and RspData to 0;
- the timer, RefreshRow, RefreshPending and RefreshOverrun to 0.
REQ-035 A request whose access is cut by Reset SHALL produce no response.

Structure
REQ-036 Package qsram_pkg SHALL hold the FSM state enum, the row-address width function and the strobe-type constants.
REQ-037 The refresh timer, RefreshPending, RefreshRow and overrun logic SHALL be sub-module qsram_refresh_timer.

Verification (ROWS=8, WIDTH=8, REFRESH_INTERVAL=16)
REQ-038 Write of 0xA5 to row 3, then read of row 3 against a cell model -> WriteEdge 2 cycles after accept with RowSelect=0x08; RspValid 4 cycles after the read is accepted with RspData=0xA5.
REQ-039 Idle for 40 cycles -> RefreshEdge at cycles 17-18 and 33-34 (rows 0 then 1); RefreshOverrun stays 0.
REQ-040 ReqValid held while the refresh terminal count occurs mid-read -> the read completes, the refresh follows, and the next request is accepted only after REF_STROBE.
REQ-041 Read of address 9 (with an 8-bit-wide address override in the bench) -> AddrError at T+1, no strobe, RspValid at T+4 with RspData=0x00.
REQ-042 Reset asserted in STROBE -> all strobes 0 on the next cycle, no RspValid, ReqReady=1 once Reset is released.
REQ-043 Back-to-back writes that keep refresh blocked (forced) for 2 intervals -> RefreshOverrun=1 and sticky; a strobe one-hot/mutex assertion holds throughout.

Source files
------------

// File: rtl/qsram_pkg.sv
// Shared types and helpers for the QSRAM access sequencer and its refresh timer.
package qsram_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETUP      = 3'd1,
        STROBE     = 3'd2,
        HOLD       = 3'd3,
        REF_SETUP  = 3'd4,
        REF_STROBE = 3'd5
    } seq_state_e;

    // Kind of cell strobe a sequence will fire
    localparam logic [1:0] STROBE_NONE    = 2'd0;
    localparam logic [1:0] STROBE_WRITE   = 2'd1;
    localparam logic [1:0] STROBE_READ    = 2'd2;
    localparam logic [1:0] STROBE_REFRESH = 2'd3;

    function automatic int row_addr_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/qsram_refresh_timer.sv
// Free-running refresh interval timer with pending request, row pointer and sticky overrun.
module qsram_refresh_timer
    import qsram_pkg::*;
#(
    parameter int ROWS             = 8,
    parameter int REFRESH_INTERVAL = 64,
    parameter int RAW              = row_addr_width(ROWS)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           refresh_done,
    output logic           refresh_pending,
    output logic           refresh_overrun,
    output logic [RAW-1:0] refresh_row
);

    localparam int TW = $clog2(REFRESH_INTERVAL);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(REFRESH_INTERVAL - 1);
    localparam logic [RAW-1:0] ROW_LAST   = RAW'(ROWS - 1);

    logic [TW-1:0]  timer_r;
    logic [RAW-1:0] row_r;
    logic           pending_r;
    logic           overrun_r;

    // Timer wrap raises a request; a wrap that finds one still pending is a missed slot
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r   <= '0;
            row_r     <= '0;
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (timer_r == TIMER_LAST) begin
                timer_r   <= '0;
                pending_r <= 1'b1;
                if (pending_r) begin
                    overrun_r <= 1'b1;
                end
            end else begin
                timer_r <= timer_r + 1'b1;
                if (refresh_done) begin
                    pending_r <= 1'b0;
                end
            end
            if (refresh_done) begin
                row_r <= (row_r == ROW_LAST) ? '0 : row_r + 1'b1;
            end
        end
    end

    assign refresh_pending = pending_r;
    assign refresh_overrun = overrun_r;
    assign refresh_row     = row_r;

endmodule

// File: rtl/qsram_access_sequencer.sv
// Sequences single-row read/write accesses and periodic refreshes onto a QSRAM cell array.
module qsram_access_sequencer
    import qsram_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int ROWS             = 8,
    parameter int REFRESH_INTERVAL = 64,
    parameter int ADDR_WIDTH       = row_addr_width(ROWS)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddr,
    input  logic [WIDTH-1:0]      ReqData,
    output logic                  RspValid,
    output logic [WIDTH-1:0]      RspData,
    output logic                  AddrError,
    output logic                  RefreshOverrun,
    output logic [ROWS-1:0]       RowSelect,
    output logic [WIDTH-1:0]      inputData,
    input  logic [WIDTH-1:0]      outputData,
    output logic                  WriteEdge,
    output logic                  ReadEdge,
    output logic                  RefreshEdge
);

    localparam int RAW = row_addr_width(ROWS);
    localparam logic [ROWS-1:0]     ROW_ONE = {{(ROWS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] ROWS_W  = (ADDR_WIDTH + 1)'(ROWS);

    seq_state_e      state_r;
    logic [ROWS-1:0] row_sel_r;
    logic [WIDTH-1:0] in_data_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic            rsp_valid_r;
    logic            addr_err_r;
    logic            write_edge_r;
    logic            read_edge_r;
    logic            refresh_edge_r;
    logic [1:0]      op_kind_r;
    logic            op_read_r;

    logic            refresh_pending;
    logic [RAW-1:0]  refresh_row;
    logic            refresh_done_s;
    logic            addr_ok_s;
    logic [ROWS-1:0] req_sel_s;

    assign refresh_done_s = (state_r == REF_STROBE);
    assign addr_ok_s      = ({1'b0, ReqAddr} < ROWS_W);
    assign req_sel_s      = addr_ok_s ? (ROW_ONE << ReqAddr) : '0;

    qsram_refresh_timer #(
        .ROWS             (ROWS),
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .RAW              (RAW)
    ) u_refresh_timer (
        .clk             (Clock),
        .reset           (Reset),
        .refresh_done    (refresh_done_s),
        .refresh_pending (refresh_pending),
        .refresh_overrun (RefreshOverrun),
        .refresh_row     (refresh_row)
    );

    // Sequencer FSM; strobes and pulses default low and are raised for one state only
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r        <= IDLE;
            row_sel_r      <= '0;
            in_data_r      <= '0;
            rsp_data_r     <= '0;
            rsp_valid_r    <= 1'b0;
            addr_err_r     <= 1'b0;
            write_edge_r   <= 1'b0;
            read_edge_r    <= 1'b0;
            refresh_edge_r <= 1'b0;
            op_kind_r      <= STROBE_NONE;
            op_read_r      <= 1'b0;
        end else begin
            rsp_valid_r    <= 1'b0;
            addr_err_r     <= 1'b0;
            write_edge_r   <= 1'b0;
            read_edge_r    <= 1'b0;
            refresh_edge_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (refresh_pending) begin
                        state_r   <= REF_SETUP;
                        row_sel_r <= ROW_ONE << refresh_row;
                        op_kind_r <= STROBE_REFRESH;
                    end else if (ReqValid) begin
                        state_r    <= SETUP;
                        row_sel_r  <= req_sel_s;
                        in_data_r  <= ReqData;
                        addr_err_r <= ~addr_ok_s;
                        op_read_r  <= ~ReqWrite;
                        // An out-of-range access runs the full sequence without touching the cells
                        if (!addr_ok_s) begin
                            op_kind_r <= STROBE_NONE;
                        end else if (ReqWrite) begin
                            op_kind_r <= STROBE_WRITE;
                        end else begin
                            op_kind_r <= STROBE_READ;
                        end
                    end
                end
                SETUP: begin
                    state_r      <= STROBE;
                    write_edge_r <= (op_kind_r == STROBE_WRITE);
                    read_edge_r  <= (op_kind_r == STROBE_READ);
                end
                STROBE: begin
                    state_r <= HOLD;
                end
                HOLD: begin
                    state_r     <= IDLE;
                    row_sel_r   <= '0;
                    in_data_r   <= '0;
                    rsp_valid_r <= op_read_r;
                    if (op_read_r) begin
                        rsp_data_r <= (op_kind_r == STROBE_READ) ? outputData : {WIDTH{1'b0}};
                    end
                end
                REF_SETUP: begin
                    state_r        <= REF_STROBE;
                    refresh_edge_r <= (op_kind_r == STROBE_REFRESH);
                end
                REF_STROBE: begin
                    state_r   <= IDLE;
                    row_sel_r <= '0;
                end
                default: begin
                    state_r   <= IDLE;
                    row_sel_r <= '0;
                    in_data_r <= '0;
                end
            endcase
        end
    end

    assign ReqReady    = (state_r == IDLE) && !refresh_pending;
    assign RowSelect   = row_sel_r;
    assign inputData   = in_data_r;
    assign RspValid    = rsp_valid_r;
    assign RspData     = rsp_data_r;
    assign AddrError   = addr_err_r;
    assign WriteEdge   = write_edge_r;
    assign ReadEdge    = read_edge_r;
    assign RefreshEdge = refresh_edge_r;

endmodule

// File: tb/tb_qsram_access_sequencer.sv
// Bench for qsram_access_sequencer: cell-array model, scheduled-event reference model and directed scenarios.
module tb_qsram_access_sequencer;

    localparam int WIDTH = 8;
    localparam int ROWS  = 8;
    localparam int RI    = 16;
    localparam int AW    = 8;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             ReqValid = 1'b0;
    logic             ReqReady;
    logic             ReqWrite = 1'b0;
    logic [AW-1:0]    ReqAddr = '0;
    logic [WIDTH-1:0] ReqData = '0;
    logic             RspValid;
    logic [WIDTH-1:0] RspData;
    logic             AddrError;
    logic             RefreshOverrun;
    logic [ROWS-1:0]  RowSelect;
    logic [WIDTH-1:0] inputData;
    logic [WIDTH-1:0] outputData = '0;
    logic             WriteEdge;
    logic             ReadEdge;
    logic             RefreshEdge;

    qsram_access_sequencer #(
        .WIDTH(WIDTH), .ROWS(ROWS), .REFRESH_INTERVAL(RI), .ADDR_WIDTH(AW)
    ) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .RspValid(RspValid), .RspData(RspData), .AddrError(AddrError),
        .RefreshOverrun(RefreshOverrun), .RowSelect(RowSelect),
        .inputData(inputData), .outputData(outputData),
        .WriteEdge(WriteEdge), .ReadEdge(ReadEdge), .RefreshEdge(RefreshEdge)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (t=%0t): got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Cell array seen by the DUT
    logic [WIDTH-1:0] cells [ROWS];

    function automatic int oh_idx(input logic [ROWS-1:0] v);
        for (int i = 0; i < ROWS; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    initial begin
        for (int i = 0; i < ROWS; i++) cells[i] = WIDTH'(i * 17);
        forever begin
            @(posedge Clock);
            if (WriteEdge) cells[oh_idx(RowSelect)] <= inputData;
            if (ReadEdge)  outputData <= cells[oh_idx(RowSelect)];
        end
    end

    // Reference model: cycle counter since reset, refresh bookkeeping, expected-event schedule
    int  cyc = 0;
    bit  model_ok = 1'b0;
    bit  force_on = 1'b0;
    int  idle_at, clear_at, m_timer, m_row;
    bit  m_pend, m_ovr;
    logic [WIDTH-1:0] m_rspd;
    logic [WIDTH-1:0] exp_mem [ROWS];
    logic [ROWS-1:0]  s_sel  [5];
    logic [WIDTH-1:0] s_in   [5];
    logic [WIDTH-1:0] s_rspd [5];
    bit s_wr [5], s_rd [5], s_ref [5], s_aerr [5], s_rsp [5];
    bit go_ref, go_acc, addr_ok, tc;
    logic [ROWS-1:0] one_row, sel;

    initial begin
        for (int i = 0; i < ROWS; i++) exp_mem[i] = WIDTH'(i * 17);
        one_row = ROWS'(1);
        forever begin
            @(posedge Clock);
            if (Reset) begin
                for (int k = 0; k < 5; k++) begin
                    s_sel[k] = '0; s_in[k] = '0; s_rspd[k] = '0;
                    s_wr[k] = 0; s_rd[k] = 0; s_ref[k] = 0; s_aerr[k] = 0; s_rsp[k] = 0;
                end
                cyc = 0; idle_at = 0; clear_at = -1; m_timer = 0; m_row = 0;
                m_pend = 0; m_ovr = 0; m_rspd = '0; model_ok = 1'b1;
            end else if (model_ok) begin
                go_ref = (cyc >= idle_at) && m_pend && !force_on;
                go_acc = (cyc >= idle_at) && !(m_pend && !force_on) && ReqValid;
                for (int k = 0; k < 4; k++) begin
                    s_sel[k] = s_sel[k+1]; s_in[k] = s_in[k+1]; s_rspd[k] = s_rspd[k+1];
                    s_wr[k] = s_wr[k+1]; s_rd[k] = s_rd[k+1]; s_ref[k] = s_ref[k+1];
                    s_aerr[k] = s_aerr[k+1]; s_rsp[k] = s_rsp[k+1];
                end
                s_sel[4] = '0; s_in[4] = '0; s_rspd[4] = '0;
                s_wr[4] = 0; s_rd[4] = 0; s_ref[4] = 0; s_aerr[4] = 0; s_rsp[4] = 0;
                if (s_rsp[0]) m_rspd = s_rspd[0];
                if (go_ref) begin
                    s_sel[0] = one_row << m_row;
                    s_sel[1] = one_row << m_row;
                    s_ref[1] = 1;
                    idle_at  = cyc + 3;
                    clear_at = cyc + 3;
                end
                if (go_acc) begin
                    addr_ok = (int'(ReqAddr) < ROWS);
                    sel = addr_ok ? (one_row << ReqAddr) : '0;
                    for (int k = 0; k < 3; k++) begin
                        s_sel[k] = sel;
                        s_in[k]  = ReqData;
                    end
                    s_aerr[0] = !addr_ok;
                    s_wr[1] = addr_ok && ReqWrite;
                    s_rd[1] = addr_ok && !ReqWrite;
                    if (!ReqWrite) begin
                        s_rsp[3]  = 1;
                        s_rspd[3] = addr_ok ? exp_mem[ReqAddr[2:0]] : '0;
                    end else if (addr_ok) begin
                        exp_mem[ReqAddr[2:0]] = ReqData;
                    end
                    idle_at = cyc + 4;
                end
                tc = (m_timer == RI - 1);
                if (tc) begin
                    if (m_pend) m_ovr = 1;
                    m_pend  = 1;
                    m_timer = 0;
                end else begin
                    m_timer++;
                    if (cyc + 1 == clear_at) m_pend = 0;
                end
                if (cyc + 1 == clear_at) m_row = (m_row + 1) % ROWS;
                cyc++;
            end
        end
    end

    // Per-cycle comparison against the model, plus strobe mutex / one-hot row invariants
    initial forever begin
        @(negedge Clock);
        if (model_ok) begin
            chk("RowSelect",      32'(RowSelect), 32'(s_sel[0]));
            chk("inputData",      32'(inputData), 32'(s_in[0]));
            chk("WriteEdge",      32'(WriteEdge), 32'(s_wr[0]));
            chk("ReadEdge",       32'(ReadEdge), 32'(s_rd[0]));
            chk("RefreshEdge",    32'(RefreshEdge), 32'(s_ref[0]));
            chk("AddrError",      32'(AddrError), 32'(s_aerr[0]));
            chk("RspValid",       32'(RspValid), 32'(s_rsp[0]));
            chk("RspData",        32'(RspData), 32'(m_rspd));
            chk("RefreshOverrun", 32'(RefreshOverrun), 32'(m_ovr));
            chk("ReqReady",       32'(ReqReady), 32'((cyc >= idle_at) && !(m_pend && !force_on)));
            chk("strobe_mutex",   32'($countones({WriteEdge, ReadEdge, RefreshEdge}) <= 1), 32'd1);
            chk("row_onehot",     32'($countones(RowSelect) <= 1), 32'd1);
        end
    end

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic at_cycle(input int target);
        int g = 0;
        @(negedge Clock);
        while (cyc < target && g < 1000) begin
            @(negedge Clock);
            g++;
        end
        chk("at_cycle", 32'(cyc), 32'(target));
    endtask

    // Call between edges; returns just after the accepting edge
    task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [WIDTH-1:0] data,
                          input bit keep, output int t_acc);
        int g = 0;
        bit done = 0;
        ReqValid = 1'b1; ReqWrite = wr; ReqAddr = addr; ReqData = data;
        t_acc = -1;
        while (!done && g < 100) begin
            @(negedge Clock);
            if (ReqReady) begin
                done  = 1;
                t_acc = cyc;
            end
            step();
            g++;
        end
        if (!keep) ReqValid = 1'b0;
        if (!done) chk("req_accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int t1, t2, tw, tr, ta, tx;

    initial begin
        repeat (3) @(posedge Clock);
        #2 Reset = 1'b0;
        at_cycle(0);
        chk("reset_rowselect", 32'(RowSelect), 32'h00);
        chk("reset_ready",     32'(ReqReady), 32'd1);

        // Idle refreshes: rows 0 then 1
        at_cycle(17);
        chk("ref0_setup_row", 32'(RowSelect), 32'h01);
        at_cycle(18);
        chk("ref0_edge", 32'(RefreshEdge), 32'd1);
        at_cycle(33);
        chk("ref1_setup_row", 32'(RowSelect), 32'h02);
        at_cycle(34);
        chk("ref1_edge", 32'(RefreshEdge), 32'd1);
        at_cycle(40);
        chk("idle_overrun", 32'(RefreshOverrun), 32'd0);

        // Terminal count lands mid-read while the next request is already waiting
        at_cycle(44);
        step();
        do_req(1'b0, 8'd3, 8'h00, 1'b1, t1);
        do_req(1'b1, 8'd5, 8'h3C, 1'b0, t2);
        chk("midread_accept", 32'(t1), 32'd45);
        chk("after_refresh_accept", 32'(t2 - t1), 32'd7);

        // Write 0xA5 to row 3, read it back
        do_req(1'b1, 8'd3, 8'hA5, 1'b0, tw);
        at_cycle(tw + 2);
        chk("wr_edge", 32'(WriteEdge), 32'd1);
        chk("wr_rowsel", 32'(RowSelect), 32'h08);
        step();
        do_req(1'b0, 8'd3, 8'h00, 1'b0, tr);
        at_cycle(tr + 4);
        chk("rd_rspvalid", 32'(RspValid), 32'd1);
        chk("rd_rspdata", 32'(RspData), 32'hA5);

        // Out-of-range read
        step();
        do_req(1'b0, 8'd9, 8'h00, 1'b0, ta);
        at_cycle(ta + 1);
        chk("oor_addrerror", 32'(AddrError), 32'd1);
        chk("oor_rowsel", 32'(RowSelect), 32'h00);
        at_cycle(ta + 2);
        chk("oor_no_strobe", 32'({WriteEdge, ReadEdge}), 32'd0);
        at_cycle(ta + 4);
        chk("oor_rspvalid", 32'(RspValid), 32'd1);
        chk("oor_rspdata", 32'(RspData), 32'h00);

        // Reset during STROBE of a read
        step();
        do_req(1'b0, 8'd2, 8'h00, 1'b0, tx);
        at_cycle(tx + 2);
        chk("pre_reset_readedge", 32'(ReadEdge), 32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        @(negedge Clock);
        chk("post_reset_strobes", 32'({WriteEdge, ReadEdge, RefreshEdge}), 32'd0);
        chk("post_reset_rowsel", 32'(RowSelect), 32'h00);
        chk("post_reset_ready", 32'(ReqReady), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chk("post_reset_no_rsp", 32'(RspValid), 32'd0);
        end

        // Refresh held off by force while writes stream for more than two intervals
        step();
        force dut.refresh_pending = 1'b0;
        force_on = 1'b1;
        for (int i = 0; i < 12; i++) begin
            do_req(1'b1, AW'(i % ROWS), WIDTH'(8'h40 + i), (i != 11), tw);
        end
        chk("overrun_set", 32'(RefreshOverrun), 32'd1);
        release dut.refresh_pending;
        force_on = 1'b0;
        repeat (20) @(negedge Clock);
        chk("overrun_sticky", 32'(RefreshOverrun), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
